// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_gen
//  Brief    : Programmable serial bit-pattern transmitter. Sends an N-bit
//             pattern MSB-first, repeats it a set number of times (0 means
//             run until abort) and can insert idle gap bits between
//             repetitions. Start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_gen #(
  parameter int W     = 8,  // maximum pattern length in bits
  parameter int LEN_W = 4,  // width of len, 2**LEN_W > W
  parameter int CNT_W = 8,  // width of the repeat counter
  parameter int GAP_W = 4   // width of the gap-length input
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state,    w_state;
  logic [W-1:0]     r_shreg,    w_shreg;
  logic [W-1:0]     r_pat,      w_pat;       // left-aligned copy for reloads
  logic [LEN_W-1:0] r_bitcnt,   w_bitcnt;
  logic [LEN_W-1:0] r_len,      w_len;
  logic [CNT_W-1:0] r_rep_left, w_rep_left;  // 0 = continuous, never decremented
  logic [GAP_W-1:0] r_gap,      w_gap;
  logic [GAP_W-1:0] r_gapcnt,   w_gapcnt;

  logic             w_len_ok;
  logic [W-1:0]     w_align;
  logic             w_last;

  // Start qualification and left alignment of the incoming pattern
  assign w_len_ok = (len != '0) && (len <= LEN_W'(W));
  assign w_align  = pattern << (LEN_W'(W) - len);
  assign w_last   = (r_bitcnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath registers: shift register, latched transfer settings, counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg    <= '0;
      r_pat      <= '0;
      r_bitcnt   <= '0;
      r_len      <= '0;
      r_rep_left <= '0;
      r_gap      <= '0;
      r_gapcnt   <= '0;
    end else begin
      r_shreg    <= w_shreg;
      r_pat      <= w_pat;
      r_bitcnt   <= w_bitcnt;
      r_len      <= w_len;
      r_rep_left <= w_rep_left;
      r_gap      <= w_gap;
      r_gapcnt   <= w_gapcnt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state    = r_state;
    w_shreg    = r_shreg;
    w_pat      = r_pat;
    w_bitcnt   = r_bitcnt;
    w_len      = r_len;
    w_rep_left = r_rep_left;
    w_gap      = r_gap;
    w_gapcnt   = r_gapcnt;

    case (r_state)
      S_IDLE: begin
        if (start && w_len_ok) begin
          w_state    = S_SEND;
          w_shreg    = w_align;
          w_pat      = w_align;
          w_len      = len;
          w_bitcnt   = len - 1'b1;
          w_rep_left = repeats;
          w_gap      = gap;
          w_gapcnt   = '0;
        end
      end

      S_SEND: begin
        if (abort) begin
          w_state = S_DONE;
        end else if (!w_last) begin
          w_shreg  = r_shreg << 1;
          w_bitcnt = r_bitcnt - 1'b1;
        end else if (r_rep_left == CNT_W'(1)) begin
          w_state = S_DONE;
        end else begin
          // Start the next repetition; a zero count means run forever
          if (r_rep_left != '0) begin
            w_rep_left = r_rep_left - 1'b1;
          end
          w_shreg  = r_pat;
          w_bitcnt = r_len - 1'b1;
          if (r_gap != '0) begin
            w_state  = S_GAP;
            w_gapcnt = r_gap - 1'b1;
          end else begin
            w_state = S_SEND;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          w_state = S_DONE;
        end else if (r_gapcnt == '0) begin
          w_state = S_SEND;
        end else begin
          w_gapcnt = r_gapcnt - 1'b1;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state
  assign valid = (r_state == S_SEND);
  assign out   = valid & r_shreg[W-1];
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_pattern_gen
//  Brief    : Scoreboard bench for serial_pattern_gen. Stimulus pushes the
//             expected bit/done sequence; a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [7:0] repeats;
  logic [3:0] gap;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;

  serial_pattern_gen #(
    .W    (8),
    .LEN_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .pattern(pattern),
    .len    (len),
    .repeats(repeats),
    .gap    (gap),
    .out    (out),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  typedef struct packed {
    logic is_done;
    logic b;
  } item_t;

  item_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    tb_cyc = 0;
  int    t_acc = 0;
  int    det_cnt = 0;
  logic [5:0] det_sh = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) q.push_back('{is_done: 1'b0, b: bits[i]});
  endtask

  task automatic push_done();
    q.push_back('{is_done: 1'b1, b: 1'b0});
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] r, input logic [3:0] g);
    @(negedge clk);
    pattern = p; len = l; repeats = r; gap = g; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t_acc = tb_cyc;
  endtask

  // Waits for done, checks the cycle it appeared in, then that busy drops.
  // With poke set, a legal start is offered during the DONE cycle.
  task automatic wait_done(input string name, input int exp, input bit poke);
    int lim;
    lim = 0;
    while (!done && lim < 500) begin
      @(posedge clk);
      #1;
      lim++;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(name, tb_cyc - t_acc + 1, exp);
      if (poke) start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    chk({name, "_busy_low"}, busy, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    item_t it;
    if (rst) begin
      if (valid || done) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {valid, done}, 2'b00);
        end else begin
          it = q.pop_front();
          if (it.is_done) chk("done_pulse", {valid, done}, 2'b01);
          else            chk("valid_bit", {valid, done, out}, {2'b10, it.b});
        end
      end else if (out !== 1'b0) begin
        chk("idle_out", out, 1'b0);
      end
    end
  end

  // Reference 110101 detector on the full line while busy
  always @(negedge clk) begin
    if (!busy) begin
      det_sh = '0;
    end else begin
      det_sh = {det_sh[4:0], out};
      if (det_sh == 6'b110101) det_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeats = '0; gap = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk) rst = 1'b1;

    // Single pass, len 6: 110101, done in cycle 7
    push_bits(32'b110101, 6);
    push_done();
    do_start(8'b00110101, 4'd6, 8'd1, 4'd0);
    wait_done("t1_done_cycle", 7, 1'b0);

    // Three passes with gap 2; a start mid-transfer must be ignored
    push_bits(32'b110101, 6);
    push_bits(32'b110101, 6);
    push_bits(32'b110101, 6);
    push_done();
    d0 = det_cnt;
    do_start(8'b00110101, 4'd6, 8'd3, 4'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; pattern = 8'hFF; len = 4'd8; repeats = 8'd0; gap = 4'd0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t2_done_cycle", 23, 1'b0);
    chk("t2_detections", det_cnt - d0, 3);

    // Continuous A5 with abort on the 20th bit
    for (int i = 0; i < 20; i++) push_bits(32'hA5 >> (7 - (i % 8)), 1);
    push_done();
    do_start(8'hA5, 4'd8, 8'd0, 4'd0);
    repeat (19) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done("t3_done_cycle", 21, 1'b0);

    // Illegal lengths are ignored
    @(negedge clk);
    start = 1'b1; pattern = 8'hFF; len = 4'd0; repeats = 8'd1; gap = 4'd0;
    @(posedge clk);
    #1;
    chk("t4_len0_busy", busy, 1'b0);
    chk("t4_len0_valid", valid, 1'b0);
    @(negedge clk) len = 4'd9;
    @(posedge clk);
    #1;
    chk("t4_len9_busy", busy, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_idle_busy", busy, 1'b0);

    // len 1, two passes, gap 1: done in cycle 4; start during DONE ignored
    push_bits(32'b1, 1);
    push_bits(32'b1, 1);
    push_done();
    do_start(8'h01, 4'd1, 8'd2, 4'd1);
    wait_done("t6_done_cycle", 4, 1'b1);
    chk("t6_after_done_valid", valid, 1'b0);

    // Asynchronous reset mid-SEND
    push_bits(32'b101, 3);
    do_start(8'hA5, 4'd8, 8'd0, 4'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_arst_out", out, 1'b0);
    chk("t5_arst_valid", valid, 1'b0);
    chk("t5_arst_busy", busy, 1'b0);
    chk("t5_arst_done", done, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_valid", valid, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
